// File: rtl/bus_arbiter_8_pkg.sv
// Shared types and constants for the two-requester round-robin bus arbiter.
// Holds the grant state encodings and the datapath width.
package bus_arbiter_8_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GNT_A = 2'b01,
        ARB_GNT_B = 2'b10
    } arb_state_t;

    localparam int DATA_W = 8;

endpackage

// File: rtl/mux_8.sv
// 2:1 mux for the arbitrated 8-bit datapath; sel=0 picks a, sel=1 picks b.
import bus_arbiter_8_pkg::*;

module mux_8 (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter giving two requesters turns on one shared 8-bit port,
// with a per-grant beat limit so a busy owner yields to a waiting peer.
import bus_arbiter_8_pkg::*;

module bus_arbiter_8 #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic [7:0] data_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    input  logic       rsc_ready,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       sel,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       ack_a,
    output logic       ack_b
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_b;
    logic [7:0]       mux_y;

    assign gnt_a     = (state == ARB_GNT_A);
    assign gnt_b     = (state == ARB_GNT_B);
    assign sel       = gnt_b;
    assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
    assign ack_a     = gnt_a & req_a & rsc_ready;
    assign ack_b     = gnt_b & req_b & rsc_ready;

    mux_8 u_mux (
        .a   (data_a),
        .b   (data_b),
        .sel (sel),
        .y   (mux_y)
    );

    assign out_data = out_valid ? mux_y : 8'h00;

    // beat_cnt saturates at HOLD_LAST so a lone owner streams forever but
    // yields on its first beat after the peer starts waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            beat_cnt <= '0;
            last_b   <= 1'b1;
        end else begin
            case (state)
                ARB_IDLE: begin
                    beat_cnt <= '0;
                    if (req_a && (!req_b || last_b))
                        state <= ARB_GNT_A;
                    else if (req_b)
                        state <= ARB_GNT_B;
                end
                ARB_GNT_A: begin
                    if (!req_a) begin
                        state    <= req_b ? ARB_GNT_B : ARB_IDLE;
                        beat_cnt <= '0;
                        last_b   <= 1'b0;
                    end else if (ack_a) begin
                        if (beat_cnt == HOLD_LAST && req_b) begin
                            state    <= ARB_GNT_B;
                            beat_cnt <= '0;
                            last_b   <= 1'b0;
                        end else if (beat_cnt != HOLD_LAST) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ARB_GNT_B: begin
                    if (!req_b) begin
                        state    <= req_a ? ARB_GNT_A : ARB_IDLE;
                        beat_cnt <= '0;
                        last_b   <= 1'b1;
                    end else if (ack_b) begin
                        if (beat_cnt == HOLD_LAST && req_a) begin
                            state    <= ARB_GNT_A;
                            beat_cnt <= '0;
                            last_b   <= 1'b1;
                        end else if (beat_cnt != HOLD_LAST) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ARB_IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Directed vector table plus a randomized fairness run for bus_arbiter_8.
module tb_bus_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b, rsc_ready;
    logic [7:0] data_a, data_b;
    logic       gnt_a, gnt_b, sel, out_valid, ack_a, ack_b;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;

    bus_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .rsc_ready (rsc_ready),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ack_a     (ack_a),
        .ack_b     (ack_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ra, rb, rdy;
        logic [7:0] da, db;
        logic       ga, gb, ov;
        logic [7:0] od;
        logic       aa, ab;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, ra, rb, rdy, input logic [7:0] da, db,
                                input logic ga, gb, ov, input logic [7:0] od,
                                input logic aa, ab);
        vec_t v;
        v.rst = rst; v.ra = ra; v.rb = rb; v.rdy = rdy; v.da = da; v.db = db;
        v.ga = ga; v.gb = gb; v.ov = ov; v.od = od; v.aa = aa; v.ab = ab;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, ra, rb, rdy, input logic [7:0] da, db);
        reset = rst; req_a = ra; req_b = rb; rsc_ready = rdy; data_a = da; data_b = db;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        int wait_a, wait_b;

        // Step 0 (row 0): start granting A with data 3C
        // Hand-computed with MAX_HOLD=4; each row is sampled before the next edge.
        vecs.push_back(mk(0,1,0,1,8'h3C,8'h00, 0,0,0,8'h00,0,0)); // 0 idle, req A
        vecs.push_back(mk(0,1,0,1,8'h3C,8'h00, 1,0,1,8'h3C,1,0)); // 1 cnt->1
        vecs.push_back(mk(0,1,0,1,8'h3C,8'h00, 1,0,1,8'h3C,1,0)); // 2 cnt->2
        vecs.push_back(mk(0,1,0,1,8'h3C,8'h00, 1,0,1,8'h3C,1,0)); // 3 cnt->3
        vecs.push_back(mk(0,1,0,1,8'h3C,8'h00, 1,0,1,8'h3C,1,0)); // 4 saturated
        vecs.push_back(mk(0,1,1,1,8'h3C,8'h5A, 1,0,1,8'h3C,1,0)); // 5 B arrives, handover
        vecs.push_back(mk(0,1,1,1,8'h3C,8'h5A, 0,1,1,8'h5A,0,1)); // 6 B beat 1
        vecs.push_back(mk(0,1,1,1,8'h3C,8'h5A, 0,1,1,8'h5A,0,1)); // 7 B beat 2
        vecs.push_back(mk(0,1,1,1,8'h3C,8'h5A, 0,1,1,8'h5A,0,1)); // 8 B beat 3
        vecs.push_back(mk(0,1,1,1,8'h3C,8'h5A, 0,1,1,8'h5A,0,1)); // 9 B beat 4, handover
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,1,1,0,8'h3C,8'h5A, 1,0,1,8'h3C,0,0)); // 10-14 stall
        vecs.push_back(mk(0,1,1,1,8'h3C,8'h5A, 1,0,1,8'h3C,1,0)); // 15 A beat, cnt->1
        vecs.push_back(mk(0,0,1,1,8'h3C,8'h5A, 1,0,0,8'h00,0,0)); // 16 A releases to B
        vecs.push_back(mk(0,0,0,1,8'h3C,8'h5A, 0,1,0,8'h00,0,0)); // 17 B releases
        vecs.push_back(mk(0,0,0,1,8'h3C,8'h5A, 0,0,0,8'h00,0,0)); // 18 idle
        vecs.push_back(mk(0,0,1,1,8'h3C,8'h77, 0,0,0,8'h00,0,0)); // 19 req B
        vecs.push_back(mk(1,0,1,1,8'h3C,8'h77, 0,1,1,8'h77,0,1)); // 20 reset mid-grant
        vecs.push_back(mk(0,1,1,1,8'h11,8'h77, 0,0,0,8'h00,0,0)); // 21 tie after reset
        vecs.push_back(mk(0,1,1,1,8'h11,8'h77, 1,0,1,8'h11,1,0)); // 22 A wins tie
        vecs.push_back(mk(0,0,0,1,8'h11,8'h77, 1,0,0,8'h00,0,0)); // 23 A releases
        vecs.push_back(mk(0,0,0,1,8'h11,8'h77, 0,0,0,8'h00,0,0)); // 24 idle

        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        checkOutput("reset_gnt", -1, {6'b0, gnt_a, gnt_b}, 8'h00);
        checkOutput("reset_valid", -1, {6'b0, out_valid, sel}, 8'h00);
        checkOutput("reset_data", -1, out_data, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].rst, vecs[i].ra, vecs[i].rb, vecs[i].rdy, vecs[i].da, vecs[i].db);
            #1;
            checkOutput("gnt_a", i, {7'b0, gnt_a}, {7'b0, vecs[i].ga});
            checkOutput("gnt_b", i, {7'b0, gnt_b}, {7'b0, vecs[i].gb});
            checkOutput("sel", i, {7'b0, sel}, {7'b0, vecs[i].gb});
            checkOutput("out_valid", i, {7'b0, out_valid}, {7'b0, vecs[i].ov});
            checkOutput("out_data", i, out_data, vecs[i].od);
            checkOutput("ack_a", i, {7'b0, ack_a}, {7'b0, vecs[i].aa});
            checkOutput("ack_b", i, {7'b0, ack_b}, {7'b0, vecs[i].ab});
        end

        // Random traffic: requests are sticky, so the wait bound must hold
        wait_a = 0;
        wait_b = 0;
        for (int c = 0; c < 10000; c++) begin
            logic ra, rb;
            @(negedge clk);
            ra = req_a ? ($urandom_range(7) != 0) : ($urandom_range(1) == 1);
            rb = req_b ? ($urandom_range(7) != 0) : ($urandom_range(1) == 1);
            applyStimulus(0, ra, rb, $urandom_range(3) != 0,
                          8'($urandom_range(255)), 8'($urandom_range(255)));
            #1;
            if (!req_a || gnt_a) wait_a = 0; else if (ack_b) wait_a++;
            if (!req_b || gnt_b) wait_b = 0; else if (ack_a) wait_b++;
            checkOutput("gnt_exclusive", c, {7'b0, gnt_a & gnt_b}, 8'h00);
            checkOutput("wait_a_bound", c, 8'(wait_a > MAX_HOLD), 8'h00);
            checkOutput("wait_b_bound", c, 8'(wait_b > MAX_HOLD), 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
